// File: rtl/control_sequencer.sv
// control_sequencer -- hardwired fetch/decode/execute control unit for the
// mini-SRC datapath.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   opcode[4:0]           IR[31:27]; sampled for dispatch in T2 only
//   con                   branch condition, used in br T6 only
//   mem_ready             memory handshake for the memory states
//   PCout Zlowout MDRout Cout                  bus drivers
//   PCin IRin MARin MDRin Yin Zin CONin IncPC  register loads
//   Gra Grb Grc Rin Rout BAout                 register select/encode
//   Read Write                                 memory strobes
//   alu_op[2:0]           0=ADD 1=SUB 2=AND 3=OR 4=INC
//   run                   low only in HALT
//   illegal               high during T2 of an undefined opcode
//
// Build option: define MEM_WAIT_EN to make the memory states (fetch T1,
// ld T6, st T7) hold until mem_ready is sampled high. Without it every
// memory state lasts exactly one cycle and mem_ready is ignored.
module control_sequencer (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [4:0] opcode,
   input  logic       con,
   input  logic       mem_ready,
   output logic       PCout,
   output logic       Zlowout,
   output logic       MDRout,
   output logic       Cout,
   output logic       PCin,
   output logic       IRin,
   output logic       MARin,
   output logic       MDRin,
   output logic       Yin,
   output logic       Zin,
   output logic       CONin,
   output logic       IncPC,
   output logic       Gra,
   output logic       Grb,
   output logic       Grc,
   output logic       Rin,
   output logic       Rout,
   output logic       BAout,
   output logic       Read,
   output logic       Write,
   output logic [2:0] alu_op,
   output logic       run,
   output logic       illegal
);

   typedef enum logic [3:0] {
      S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_e;

   typedef enum logic [4:0] {
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
      OP_ANDI, OP_ORI, OP_BR, OP_NOP, OP_HALT
   } opcode_e;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_INC
   } alu_e;

   state_e     state_q, state_d;
   logic [4:0] op_q, op_d;
   logic       mem_done;

`ifdef MEM_WAIT_EN
   assign mem_done = mem_ready;
`else
   logic mem_ready_unused;
   assign mem_ready_unused = mem_ready;
   assign mem_done         = 1'b1;
`endif

   // Decode classes of the latched opcode (valid from T3 on)
   logic is_rr, is_imm, is_ld, is_ldi, is_st, is_br;
   assign is_rr  = (op_q >= OP_ADD) && (op_q <= OP_OR);
   assign is_imm = (op_q >= OP_ADDI) && (op_q <= OP_ORI);
   assign is_ld  = (op_q == OP_LD);
   assign is_ldi = (op_q == OP_LDI);
   assign is_st  = (op_q == OP_ST);
   assign is_br  = (op_q == OP_BR);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      unique case (state_q)
         S_RST: state_d = S_T0;
         S_T0:  state_d = S_T1;
         S_T1:  if (mem_done) state_d = S_T2;
         S_T2: begin
            op_d = opcode;
            if (opcode == OP_HALT)
               state_d = S_HALT;
            else if ((opcode == OP_NOP) || (opcode > OP_HALT))
               state_d = S_T0;
            else
               state_d = S_T3;
         end
         S_T3: state_d = S_T4;
         S_T4: state_d = S_T5;
         S_T5: state_d = (is_ld || is_st || is_br) ? S_T6 : S_T0;
         S_T6: begin
            if (is_br)
               state_d = S_T0;
            else if (is_st || mem_done)
               state_d = S_T7;
         end
         S_T7:   if (is_ld || mem_done) state_d = S_T0;
         S_HALT: state_d = S_HALT;
         default: state_d = S_RST;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_RST;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   // ALU function for the execute-phase Z load in T4
   alu_e alu_t4;
   always_comb begin
      unique case (op_q)
         OP_SUB:          alu_t4 = ALU_SUB;
         OP_AND, OP_ANDI: alu_t4 = ALU_AND;
         OP_OR,  OP_ORI:  alu_t4 = ALU_OR;
         default:         alu_t4 = ALU_ADD;
      endcase
   end

   always_comb begin
      {PCout, Zlowout, MDRout, Cout}                       = '0;
      {PCin, IRin, MARin, MDRin, Yin, Zin, CONin, IncPC}   = '0;
      {Gra, Grb, Grc, Rin, Rout, BAout}                    = '0;
      {Read, Write, illegal}                               = '0;
      alu_op = ALU_ADD;
      run    = (state_q != S_HALT);
      unique case (state_q)
         S_T0: begin
            PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            alu_op = ALU_INC;
         end
         S_T1: begin
            Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
         end
         S_T2: begin
            MDRout  = 1'b1; IRin = 1'b1;
            illegal = (opcode > OP_HALT);
         end
         S_T3: begin
            if (is_br) begin
               Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
            end else begin
               Grb = 1'b1; Yin = 1'b1;
               // ld/ldi/st form the address from R0-as-zero via BAout
               if (is_ld || is_ldi || is_st) BAout = 1'b1;
               else                          Rout  = 1'b1;
            end
         end
         S_T4: begin
            if (is_br) begin
               PCout = 1'b1; Yin = 1'b1;
            end else begin
               Zin    = 1'b1;
               alu_op = alu_t4;
               if (is_rr) begin
                  Grc = 1'b1; Rout = 1'b1;
               end else begin
                  Cout = 1'b1;
               end
            end
         end
         S_T5: begin
            if (is_br) begin
               Cout = 1'b1; Zin = 1'b1;
            end else if (is_ld || is_st) begin
               Zlowout = 1'b1; MARin = 1'b1;
            end else if (is_rr || is_imm || is_ldi) begin
               Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end
         end
         S_T6: begin
            if (is_ld) begin
               Read = 1'b1; MDRin = 1'b1;
            end else if (is_st) begin
               Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
            end else if (is_br && con) begin
               Zlowout = 1'b1; PCin = 1'b1;
            end
         end
         S_T7: begin
            if (is_ld) begin
               MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (is_st) begin
               Write = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule
